// File: rtl/dm_wb_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back cache.
// Optional flush states exist only when DM_WB_CACHE_FLUSH_EN is defined.
package dm_wb_cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWbReq,
    StRfReq,
    StRfWait
`ifdef DM_WB_CACHE_FLUSH_EN
    ,
    StFlScan,
    StFlWb
`endif
  } state_e;

  typedef enum logic {
    ReqRead  = 1'b0,
    ReqWrite = 1'b1
  } req_type_e;

  function automatic int unsigned off_w(int unsigned data_w, int unsigned words_per_block);
    return $clog2(words_per_block * data_w / 8);
  endfunction

  function automatic int unsigned idx_w(int unsigned num_rows);
    return $clog2(num_rows);
  endfunction

  function automatic int unsigned tag_w(int unsigned addr_w, int unsigned data_w,
                                        int unsigned words_per_block, int unsigned num_rows);
    return addr_w - off_w(data_w, words_per_block) - idx_w(num_rows);
  endfunction

endpackage

// File: rtl/dm_wb_cache_if.sv
// Load/store request port and block-wide memory port of dm_wb_cache.
// slave is the cache view; master is the pipeline/memory environment view.
interface dm_wb_cache_if #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 2
);
  localparam int unsigned LINE_W = DATA_W * WORDS_PER_BLOCK;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req_valid, mem_req_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req_valid, mem_req_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dm_wb_cache_tagram.sv
// Per-row valid/dirty/tag storage; valid and dirty clear on reset, tags do not.
// Single port: one row index serves both the combinational read and the write.
module dm_wb_cache_tagram #(
  parameter int unsigned NUM_ROWS = 8,
  parameter int unsigned TAG_W    = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_ROWS)-1:0] i_idx,
  input  logic                        i_fill,
  input  logic [TAG_W-1:0]            i_tag,
  input  logic                        i_set_dirty,
  input  logic                        i_clr_dirty,
  input  logic                        i_clr_all,
  output logic                        o_valid,
  output logic                        o_dirty,
  output logic [TAG_W-1:0]            o_tag
);

  logic [NUM_ROWS-1:0] r_valid;
  logic [NUM_ROWS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag [NUM_ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill) begin
        r_valid[i_idx] <= 1'b1;
        r_dirty[i_idx] <= 1'b0;
      end
      if (i_set_dirty) r_dirty[i_idx] <= 1'b1;
      if (i_clr_dirty) r_dirty[i_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_fill) r_tag[i_idx] <= i_tag;
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];

endmodule

// File: rtl/dm_wb_cache.sv
// Direct-mapped write-back, write-allocate cache, one outstanding request.
// Define DM_WB_CACHE_FLUSH_EN to add flush_req/flush_done and the flush walker.
module dm_wb_cache
  import dm_wb_cache_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned NUM_ROWS        = 8,
  parameter int unsigned WORDS_PER_BLOCK = 2
) (
  input  logic clk,
  input  logic rst_n,
  dm_wb_cache_if.slave bus
`ifdef DM_WB_CACHE_FLUSH_EN
  ,
  input  logic flush_req,
  output logic flush_done
`endif
);

  localparam int unsigned LINE_W = DATA_W * WORDS_PER_BLOCK;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BOFF_W = $clog2(BYTES);
  localparam int unsigned OFF_W  = off_w(DATA_W, WORDS_PER_BLOCK);
  localparam int unsigned IDX_W  = idx_w(NUM_ROWS);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, DATA_W, WORDS_PER_BLOCK, NUM_ROWS);
  localparam int unsigned WSEL_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(WORDS_PER_BLOCK * BYTES - 1);

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_addr;
  req_type_e         r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_data [NUM_ROWS];
  logic              r_resp_valid, r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic [IDX_W-1:0]  w_req_idx, w_idx;
  logic [TAG_W-1:0]  w_req_tag, w_tag;
  logic [WSEL_W-1:0] w_wsel;
  logic [LINE_W-1:0] w_line;
  logic [DATA_W-1:0] w_word;
  logic              w_valid, w_dirty, w_hit, w_misaligned;
  logic              w_accept, w_fill, w_set_dirty, w_clr_dirty, w_clr_all;
  logic              w_resp, w_err, w_word_we;
  logic              w_mem_valid, w_mem_write;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [LINE_W-1:0] w_mem_wdata;

  assign w_req_idx = r_addr[OFF_W +: IDX_W];
  assign w_req_tag = r_addr[ADDR_W-1 -: TAG_W];

  if (WORDS_PER_BLOCK > 1) begin : g_wsel
    assign w_wsel = r_addr[BOFF_W +: WSEL_W];
  end else begin : g_wsel_single
    assign w_wsel = '0;
  end

`ifdef DM_WB_CACHE_FLUSH_EN
  logic [IDX_W-1:0] r_row;
  logic             r_flush_done;
  logic             w_row_inc, w_flush_end;

  // The flush walker owns the row index while scanning.
  assign w_idx = (r_state == StFlScan || r_state == StFlWb) ? r_row : w_req_idx;
  assign flush_done = r_flush_done;
  assign bus.req_ready = (r_state == StIdle) && !flush_req;
`else
  assign w_idx = w_req_idx;
  assign bus.req_ready = (r_state == StIdle);
`endif

  assign w_line       = r_data[w_idx];
  assign w_word       = w_line[w_wsel*DATA_W +: DATA_W];
  assign w_misaligned = |(r_addr & ALIGN_MASK);
  assign w_hit        = w_valid && (w_tag == w_req_tag);

  dm_wb_cache_tagram #(
    .NUM_ROWS (NUM_ROWS),
    .TAG_W    (TAG_W)
  ) u_tagram (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_idx       (w_idx),
    .i_fill      (w_fill),
    .i_tag       (w_req_tag),
    .i_set_dirty (w_set_dirty),
    .i_clr_dirty (w_clr_dirty),
    .i_clr_all   (w_clr_all),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_tag)
  );

  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_fill      = 1'b0;
    w_set_dirty = 1'b0;
    w_clr_dirty = 1'b0;
    w_clr_all   = 1'b0;
    w_resp      = 1'b0;
    w_err       = 1'b0;
    w_word_we   = 1'b0;
    w_mem_valid = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
`ifdef DM_WB_CACHE_FLUSH_EN
    w_row_inc   = 1'b0;
    w_flush_end = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
`ifdef DM_WB_CACHE_FLUSH_EN
        if (flush_req) begin
          w_state_d = StFlScan;
        end else
`endif
        if (bus.req_valid) begin
          w_accept  = 1'b1;
          w_state_d = StCompare;
        end
      end
      StCompare: begin
        if (w_misaligned) begin
          w_resp    = 1'b1;
          w_err     = 1'b1;
          w_state_d = StIdle;
        end else if (w_hit) begin
          w_resp      = 1'b1;
          w_word_we   = (r_write == ReqWrite);
          w_set_dirty = (r_write == ReqWrite);
          w_state_d   = StIdle;
        end else if (w_valid && w_dirty) begin
          w_state_d = StWbReq;
        end else begin
          w_state_d = StRfReq;
        end
      end
      StWbReq: begin
        w_mem_valid = 1'b1;
        w_mem_write = 1'b1;
        w_mem_addr  = ADDR_W'({w_tag, w_idx}) << OFF_W;
        w_mem_wdata = w_line;
        if (bus.mem_req_ready) begin
          w_clr_dirty = 1'b1;
          w_state_d   = StRfReq;
        end
      end
      StRfReq: begin
        w_mem_valid = 1'b1;
        w_mem_addr  = r_addr & ~LINE_MASK;
        if (bus.mem_req_ready) w_state_d = StRfWait;
      end
      StRfWait: begin
        if (bus.mem_rvalid) begin
          w_fill    = 1'b1;
          w_state_d = StCompare;
        end
      end
`ifdef DM_WB_CACHE_FLUSH_EN
      StFlScan: begin
        if (w_valid && w_dirty) begin
          w_state_d = StFlWb;
        end else if (r_row == IDX_W'(NUM_ROWS - 1)) begin
          w_flush_end = 1'b1;
          w_clr_all   = 1'b1;
          w_state_d   = StIdle;
        end else begin
          w_row_inc = 1'b1;
        end
      end
      StFlWb: begin
        w_mem_valid = 1'b1;
        w_mem_write = 1'b1;
        w_mem_addr  = ADDR_W'({w_tag, w_idx}) << OFF_W;
        w_mem_wdata = w_line;
        // Back to the scan: the now-clean row advances on the next cycle.
        if (bus.mem_req_ready) begin
          w_clr_dirty = 1'b1;
          w_state_d   = StFlScan;
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_write      <= ReqRead;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_state_d;
      r_resp_valid <= w_resp;
      r_resp_err   <= w_err;
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_write <= req_type_e'(bus.req_write);
        r_wdata <= bus.req_wdata;
      end
      if (w_resp && !w_err) r_resp_rdata <= w_word_we ? r_wdata : w_word;
    end
  end

`ifdef DM_WB_CACHE_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row        <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= w_flush_end;
      if (w_flush_end)    r_row <= '0;
      else if (w_row_inc) r_row <= r_row + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_fill)         r_data[w_idx] <= bus.mem_rdata;
    else if (w_word_we) r_data[w_idx][w_wsel*DATA_W +: DATA_W] <= r_wdata;
  end

  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_rdata    = r_resp_rdata;
  assign bus.resp_err      = r_resp_err;
  assign bus.mem_req_valid = w_mem_valid;
  assign bus.mem_req_write = w_mem_write;
  assign bus.mem_addr      = w_mem_addr;
  assign bus.mem_wdata     = w_mem_wdata;

endmodule

// File: tb/tb_dm_wb_cache.sv
// Directed bench for dm_wb_cache with a response scoreboard and a scripted memory.
// The flush sequence runs only when DM_WB_CACHE_FLUSH_EN is defined.
module tb_dm_wb_cache;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic        chk_data;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic mem_idle_exp = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_wb_cache_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(2)) bus ();

`ifdef DM_WB_CACHE_FLUSH_EN
  logic flush_req = 1'b0;
  logic flush_done;
  dm_wb_cache #(.ADDR_W(16), .DATA_W(16), .NUM_ROWS(8), .WORDS_PER_BLOCK(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush_req  (flush_req),
    .flush_done (flush_done)
  );
`else
  dm_wb_cache #(.ADDR_W(16), .DATA_W(16), .NUM_ROWS(8), .WORDS_PER_BLOCK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", nm, got, exp);
    end
  endtask

  // Latency is counted to the clock edge at which resp_valid is sampled high.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL resp_unexpected: observed %0d queued expected >0", q.size());
      end
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("resp_err", 64'(bus.resp_err), 64'(mon_e.err));
        if (mon_e.chk_data) chk("resp_rdata", 64'(bus.resp_rdata), 64'(mon_e.rdata));
        if (mon_e.lat != 0) chk("resp_latency", 64'(cyc - acc_cyc + 1), 64'(mon_e.lat));
      end
    end
    if (rst_n && mem_idle_exp) chk("no_mem_req", 64'(bus.mem_req_valid), 64'h0);
  end

  task automatic expect_resp(input logic [15:0] rd, input logic err, input logic cd,
                             input int lat);
    exp_t e;
    e.rdata = rd; e.err = err; e.chk_data = cd; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", 64'(bus.req_ready), 64'h1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("resp_wait", 64'(q.size()), 64'h0);
  endtask

  task automatic mem_expect(input string nm, input logic wr, input logic [15:0] addr,
                            input logic [31:0] wd, input int hold, input logic refill,
                            input logic [31:0] rd);
    int n = 0;
    mem_idle_exp = 1'b0;
    @(negedge clk);
    while (!bus.mem_req_valid && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_valid"}, 64'(bus.mem_req_valid), 64'h1);
    chk({nm, "_write"}, 64'(bus.mem_req_write), 64'(wr));
    chk({nm, "_addr"}, 64'(bus.mem_addr), 64'(addr));
    if (wr) chk({nm, "_wdata"}, 64'(bus.mem_wdata), 64'(wd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 64'(bus.mem_req_valid), 64'h1);
      chk({nm, "_hold_addr"}, 64'(bus.mem_addr), 64'(addr));
      chk({nm, "_hold_write"}, 64'(bus.mem_req_write), 64'(wr));
    end
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    if (refill) begin
      @(negedge clk);
      chk({nm, "_drop"}, 64'(bus.mem_req_valid), 64'h0);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = rd;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'h1);
    chk({nm, "_resp_valid"}, 64'(bus.resp_valid), 64'h0);
    chk({nm, "_resp_err"}, 64'(bus.resp_err), 64'h0);
    chk({nm, "_resp_rdata"}, 64'(bus.resp_rdata), 64'h0);
    chk({nm, "_mem_valid"}, 64'(bus.mem_req_valid), 64'h0);
    chk({nm, "_mem_write"}, 64'(bus.mem_req_write), 64'h0);
    chk({nm, "_mem_addr"}, 64'(bus.mem_addr), 64'h0);
    chk({nm, "_mem_wdata"}, 64'(bus.mem_wdata), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Cold miss: one refill, low word returned.
    expect_resp(16'h1234, 1'b0, 1'b1, 0);
    do_req(1'b0, 16'h0004, 16'h0);
    mem_expect("rf_0004", 1'b0, 16'h0004, 32'h0, 0, 1'b1, 32'hBEEF1234);
    wait_resp();

    // Hit on the upper word, two-cycle latency, no memory traffic.
    mem_idle_exp = 1'b1;
    expect_resp(16'hBEEF, 1'b0, 1'b1, 2);
    do_req(1'b0, 16'h0006, 16'h0);
    wait_resp();

    // Store hit echoes the stored word and dirties row 1.
    expect_resp(16'hDEAD, 1'b0, 1'b1, 2);
    do_req(1'b1, 16'h0004, 16'hDEAD);
    wait_resp();

    // Conflict miss on a dirty row: writeback then refill.
    expect_resp(16'h5678, 1'b0, 1'b1, 0);
    do_req(1'b0, 16'h0024, 16'h0);
    mem_expect("wb_0004", 1'b1, 16'h0004, 32'hBEEFDEAD, 0, 1'b0, 32'h0);
    mem_expect("rf_0024", 1'b0, 16'h0024, 32'h0, 0, 1'b1, 32'hCAFE5678);
    wait_resp();

    // Misaligned load errors out without memory traffic; next request still works.
    mem_idle_exp = 1'b1;
    expect_resp(16'h0, 1'b1, 1'b0, 2);
    do_req(1'b0, 16'h0003, 16'h0);
    wait_resp();
    expect_resp(16'hCAFE, 1'b0, 1'b1, 2);
    do_req(1'b0, 16'h0026, 16'h0);
    wait_resp();

    // Refill request held off for 5 cycles, then reset during the refill wait.
    do_req(1'b0, 16'h0044, 16'h0);
    mem_expect("rf_0044", 1'b0, 16'h0044, 32'h0, 5, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #1 chk_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Everything invalid after reset: reload misses.
    expect_resp(16'h2222, 1'b0, 1'b1, 0);
    do_req(1'b0, 16'h0004, 16'h0);
    mem_expect("rf_reload", 1'b0, 16'h0004, 32'h0, 0, 1'b1, 32'h11112222);
    wait_resp();

`ifdef DM_WB_CACHE_FLUSH_EN
    begin
      int n = 0;
      int extra = 0;
      logic seen = 1'b0;
      mem_idle_exp = 1'b1;
      expect_resp(16'hDEAD, 1'b0, 1'b1, 2);
      do_req(1'b1, 16'h0004, 16'hDEAD);
      wait_resp();
      expect_resp(16'hABCD, 1'b0, 1'b1, 0);
      do_req(1'b1, 16'h0014, 16'hABCD);
      mem_expect("fl_rf5", 1'b0, 16'h0014, 32'h0, 0, 1'b1, 32'h33334444);
      wait_resp();
      @(negedge clk);
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      mem_expect("fl_wb1", 1'b1, 16'h0004, 32'h1111DEAD, 0, 1'b0, 32'h0);
      mem_expect("fl_wb5", 1'b1, 16'h0014, 32'h3333ABCD, 0, 1'b0, 32'h0);
      while (!seen && n < 50) begin
        @(negedge clk);
        if (bus.mem_req_valid) extra++;
        if (flush_done) seen = 1'b1;
        n++;
      end
      chk("fl_done", 64'(seen), 64'h1);
      chk("fl_extra_wb", 64'(extra), 64'h0);
      expect_resp(16'h6666, 1'b0, 1'b1, 0);
      do_req(1'b0, 16'h0004, 16'h0);
      mem_expect("fl_reload", 1'b0, 16'h0004, 32'h0, 0, 1'b1, 32'h55556666);
      wait_resp();
    end
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_wb_cache.md
Name: dm_wb_cache

Overview:
- Parametrised, synthesizable direct-mapped write-back, write-allocate cache between a single-request load/store port and a block-wide memory port.
- Replaces the earlier behavioural cache: explicit FSM, dirty bits, valid/ready handshakes, configurable geometry.
- Sits between the pipeline memory stage and RAM; one outstanding request at a time.

Parameters:
ADDR_W, 16, byte-address width
DATA_W, 16, word width in bits; multiple of 8
NUM_ROWS, 8, cache lines; power of 2, >=2
WORDS_PER_BLOCK, 2, words per line; power of 2, >=1; line width LINE_W = DATA_W*WORDS_PER_BLOCK

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  cache can accept (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_rdata  out  DATA_W  load data, or stored word on writes
resp_err  out  1  valid with resp_valid; misaligned address
mem_req_valid  out  1  memory transaction request
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1 = line writeback, 0 = line refill
mem_addr  out  ADDR_W  line-aligned byte address
mem_wdata  out  LINE_W  writeback line
mem_rvalid  in  1  refill data valid (one cycle)
mem_rdata  in  LINE_W  refill line

Behaviour:
- Clock/reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Address split: offset = log2(WORDS_PER_BLOCK*DATA_W/8) LSBs; index = next log2(NUM_ROWS) bits; tag = remaining MSBs. Word w of a line occupies line bits [w*DATA_W +: DATA_W].
- Reset: state IDLE; all valid and dirty bits 0; req_ready 1; resp_valid, resp_err, mem_req_valid, mem_req_write 0; resp_rdata, mem_addr, mem_wdata 0. Data and tag arrays are not reset.
- FSM states: IDLE, COMPARE, WB_REQ, RF_REQ, RF_WAIT (+ FL_SCAN, FL_WB with the optional feature).
- IDLE: req_valid && req_ready registers addr, write and wdata; go to COMPARE.
- COMPARE, misaligned (addr not a multiple of DATA_W/8): resp_valid=1, resp_err=1 next cycle; no state, array or memory change; go to IDLE.
- COMPARE, hit (valid && tag match):
  - Load returns the word.
  - Store writes the word and sets dirty; resp_rdata = stored word.
  - resp_valid asserts on the cycle after COMPARE. Hit latency is 2 cycles from the acceptance edge; go to IDLE.
- COMPARE, miss, line dirty: go to WB_REQ. Miss, line clean or invalid: go to RF_REQ.
- WB_REQ: mem_req_valid=1, mem_req_write=1, mem_addr={old_tag, index, 0}, mem_wdata=line. On mem_req_ready, clear dirty and go to RF_REQ.
- RF_REQ: mem_req_valid=1, mem_req_write=0, mem_addr = request address with offset zeroed. On mem_req_ready, go to RF_WAIT.
- RF_WAIT: on mem_rvalid, write line, set valid, write tag, clear dirty; go to COMPARE. The retry then hits.
- Memory handshake rule: once mem_req_valid is high, mem_req_valid, mem_req_write, mem_addr and mem_wdata stay stable until the cycle mem_req_ready is sampled high. mem_req_valid drops the next cycle.
- mem_rvalid outside RF_WAIT is ignored. mem_rvalid in the same cycle as the RF_REQ handshake is not accepted.
- Reset mid-operation abandons any memory transaction; mem_req_valid falls immediately (asynchronous). The interrupted line stays invalid.
- Index and word arithmetic wraps naturally within the field widths; tag compare is exact.

Optional Feature:
- Macro: DM_WB_CACHE_FLUSH_EN.
- With the macro: adds ports flush_req (in, 1) and flush_done (out, 1-cycle pulse).
  - flush_req is sampled only in IDLE and has priority over req_valid; req_ready is 0 during flush.
  - FL_SCAN walks rows 0..NUM_ROWS-1. Each valid dirty row goes through FL_WB, using the WB_REQ handshake rules.
  - After the last row: all valid and dirty bits cleared, flush_done pulses, state IDLE.
- Without the macro: no flush ports, states or logic.

Decomposition:
- Package dm_wb_cache_pkg: state enum, request-type enum (READ/WRITE, shared with the pipeline), localparam helpers for offset/index/tag widths.
- One sub-module: dm_wb_cache_tagram (valid/dirty/tag arrays with async clear, single read/write port).
- Data array stays inline.

Test Plan (defaults: offset 2b, index 3b, tag 11b):
- Reset, load 0x0004; memory returns 0xBEEF1234 -> one refill at mem_addr 0x0004, resp_rdata 0x1234, resp_err 0.
- Then load 0x0006 -> hit, no mem_req_valid, resp_rdata 0xBEEF exactly 2 cycles after acceptance.
- Store 0xDEAD to 0x0004, then load 0x0024 -> writeback mem_addr 0x0004, mem_wdata 0xBEEFDEAD; then refill at 0x0024; response carries the new low word.
- Load 0x0003 -> resp_valid with resp_err 1, no mem_req_valid, next request accepted normally.
- Hold mem_req_ready low 5 cycles in RF_REQ -> mem_req_valid and mem_addr stable. Assert rst_n=0 in RF_WAIT -> outputs at reset values; reload of 0x0004 misses.
- With DM_WB_CACHE_FLUSH_EN: dirty rows 1 and 5, flush_req -> exactly two writebacks in row order, flush_done pulse, then load 0x0004 misses.
